// File: rtl/rom_stream_reader.sv
// rom_stream_reader: read-side master for a single-port synchronous ROM.
// A start command fetches len consecutive words from base and presents them
// on a valid/ready stream. A 2-entry buffer absorbs the one-cycle ROM read
// latency and downstream backpressure.
module rom_stream_reader #(
  parameter int DW = 8,
  parameter int MD = 1024,
  parameter int AW = $clog2(MD),
  parameter int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          rom_rd,
  output logic [AW-1:0] rom_adr,
  input  logic [DW-1:0] rom_dat_r,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_adr;
  logic [LW-1:0] r_rem_iss;
  logic [LW-1:0] r_rem_acc;
  logic          r_infl;
  logic [1:0]    r_occ;
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;

  logic          w_pop;
  logic          w_issue;
  logic [2:0]    w_level;
  logic [2:0]    w_limit;

  // Head of the buffer is the stream output; the address counter drives the ROM.
  assign out_vld = (r_occ != 2'd0);
  assign out_dat = r_buf0;
  assign rom_adr = r_adr;
  assign w_pop   = out_vld & out_rdy;

  // Buffer level including the word still in flight from the ROM; a new read
  // may only be issued if that word plus the new one will fit after the pop.
  assign w_level = {1'b0, r_occ} + {2'b00, r_infl};
  assign w_limit = 3'd2 + {2'b00, w_pop};
  assign w_issue = (r_state == S_RUN) && (r_rem_iss != {LW{1'b0}}) && (w_level < w_limit);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (clk_en) begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: RUN ends in the cycle the last word is accepted downstream.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (len == {LW{1'b0}}) ? S_DONE : S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_pop && (r_rem_acc == LW'(1))) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from state; rom_rd follows the issue condition.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    rom_rd = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_RUN: begin
        busy   = 1'b1;
        rom_rd = w_issue;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Command counters and address counter; the address wraps at MD-1 by compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adr     <= {AW{1'b0}};
      r_rem_iss <= {LW{1'b0}};
      r_rem_acc <= {LW{1'b0}};
      r_infl    <= 1'b0;
    end else if (clk_en) begin
      if ((r_state == S_IDLE) && start) begin
        r_adr     <= base;
        r_rem_iss <= len;
        r_rem_acc <= len;
      end else begin
        if (w_issue) begin
          r_adr     <= (r_adr == AW'(MD - 1)) ? {AW{1'b0}} : r_adr + AW'(1);
          r_rem_iss <= r_rem_iss - LW'(1);
        end
        if (w_pop) begin
          r_rem_acc <= r_rem_acc - LW'(1);
        end
      end
      r_infl <= w_issue;
    end
  end

  // Two-entry output buffer: capture the ROM word when a read is in flight,
  // shift the second entry to the head on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ  <= 2'd0;
      r_buf0 <= {DW{1'b0}};
      r_buf1 <= {DW{1'b0}};
    end else if (clk_en) begin
      case ({r_infl, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= rom_dat_r;
          end else begin
            r_buf1 <= rom_dat_r;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= rom_dat_r;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= rom_dat_r;
          end
        end
        default: begin
          r_occ <= r_occ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Testbench for rom_stream_reader: directed commands against a ROM model with
// mem[i]=i, a scoreboard of expected words and addresses, and a monitor that
// checks the issue rule, stall stability and done pulses.
module tb_rom_stream_reader;

  localparam int DW = 8;
  localparam int MD = 16;
  localparam int AW = 4;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, rom_rd, out_vld;
  logic [AW-1:0] rom_adr;
  logic [DW-1:0] rom_dat_r;
  logic          out_rdy = 1'b1;
  logic [DW-1:0] out_dat;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] adr_q[$];

  int            m_occ = 0;
  int            m_infl = 0;
  int            m_pop = 0;
  int            n_pop = 0;
  int            done_cnt = 0;
  bit            stall = 1'b0;
  logic [DW-1:0] stall_dat = '0;
  logic [DW-1:0] exp_w;
  logic [AW-1:0] exp_a;

  bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  rom_stream_reader #(.DW(DW), .MD(MD), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .rom_rd(rom_rd), .rom_adr(rom_adr),
    .rom_dat_r(rom_dat_r), .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat)
  );

  always #5 clk = ~clk;

  // ROM model: registered read gated by clk_en & rd, contents mem[i]=i.
  always @(posedge clk) begin
    if (clk_en && rom_rd) rom_dat_r <= DW'(rom_adr);
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor, sampled mid-cycle: decides what the coming active edge will do.
  always @(negedge clk) begin
    if (rst) begin
      m_occ  = 0;
      m_infl = 0;
      stall  = 1'b0;
    end else if (clk_en) begin
      m_pop = (out_vld && out_rdy) ? 1 : 0;
      chk(out_vld, (m_occ != 0), "out_vld_vs_occ");
      if (stall) chk(out_dat, stall_dat, "stall_stable");
      if (rom_rd) begin
        chk((m_occ + m_infl - m_pop) < 2, 1, "issue_rule");
        if (adr_q.size() == 0) begin
          chk(1, 0, "rom_rd_extra");
        end else begin
          exp_a = adr_q.pop_front();
          chk(rom_adr, exp_a, "rom_adr");
        end
      end
      if (m_pop == 1) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          chk(1, 0, "word_extra");
        end else begin
          exp_w = exp_q.pop_front();
          chk(out_dat, exp_w, "out_dat");
        end
      end
      if (done) done_cnt++;
      stall     = out_vld && !out_rdy;
      stall_dat = out_dat;
      m_occ     = m_occ + m_infl - m_pop;
      m_infl    = rom_rd ? 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input int b, input int l);
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(DW'((b + i) % MD));
      adr_q.push_back(AW'((b + i) % MD));
    end
    base  = AW'(b);
    len   = LW'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(done, 1, {tag, "_done"});
    tick();
    chk(done, 0, {tag, "_done_once"});
    chk(busy, 0, {tag, "_busy_after"});
    chk(exp_q.size(), 0, {tag, "_all_words"});
  endtask

  initial begin
    int n;
    // Reset state
    tick();
    tick();
    chk(busy, 0, "rst_busy");
    chk(done, 0, "rst_done");
    chk(rom_rd, 0, "rst_rom_rd");
    chk(rom_adr, 0, "rst_rom_adr");
    chk(out_vld, 0, "rst_out_vld");
    chk(out_dat, 0, "rst_out_dat");
    rst = 1'b0;
    tick();

    // Basic stream, latency and throughput
    issue_cmd(5, 4);
    chk(busy, 1, "t1_busy");
    chk(out_vld, 0, "t1_vld_c1");
    tick();
    chk(out_vld, 0, "t1_vld_c2");
    tick();
    chk(out_vld, 1, "t1_vld_first");
    chk(out_dat, 5, "t1_first_dat");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(out_vld, 1, "t1_vld_back2back");
    end
    wait_done("t1");

    // Address wrap
    issue_cmd(14, 4);
    wait_done("t2");

    // Backpressure pattern
    issue_cmd(0, 8);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      out_rdy = pat[n % 8];
      tick();
      n++;
    end
    out_rdy = 1'b1;
    wait_done("t3");

    // Zero-length command
    issue_cmd(7, 0);
    chk(done, 1, "t4_done_next");
    chk(rom_rd, 0, "t4_no_rd");
    chk(out_vld, 0, "t4_no_vld");
    wait_done("t4");

    // start during RUN is ignored
    out_rdy = 1'b0;
    issue_cmd(4, 3);
    tick();
    base  = AW'(0);
    len   = LW'(5);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk(out_vld, 1, "t4b_held_vld");
    chk(out_dat, 4, "t4b_held_dat");
    tick();
    out_rdy = 1'b1;
    wait_done("t4b");

    // clk_en freeze mid-stream
    issue_cmd(3, 6);
    tick();
    tick();
    tick();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(out_dat, 4, "t6_frozen_dat");
      chk(rom_adr, 6, "t6_frozen_adr");
      chk(out_vld, 1, "t6_frozen_vld");
    end
    clk_en = 1'b1;
    wait_done("t6");

    // Async reset mid-transfer, then a clean restart
    n_pop = 0;
    issue_cmd(2, 6);
    n = 0;
    while (n_pop < 2 && n < 50) begin
      tick();
      n++;
    end
    chk(n_pop, 2, "t5_two_words");
    #2;
    rst = 1'b1;
    #1;
    chk(busy, 0, "t5_rst_busy");
    chk(done, 0, "t5_rst_done");
    chk(rom_rd, 0, "t5_rst_rom_rd");
    chk(rom_adr, 0, "t5_rst_rom_adr");
    chk(out_vld, 0, "t5_rst_out_vld");
    chk(out_dat, 0, "t5_rst_out_dat");
    exp_q.delete();
    adr_q.delete();
    tick();
    rst = 1'b0;
    tick();
    issue_cmd(9, 3);
    wait_done("t5");

    chk(done_cnt, 7, "done_pulse_count");
    chk(adr_q.size(), 0, "all_reads_issued");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
